// File: rtl/control_unit_if.sv
// Control-unit <-> datapath signal bundle.
//   slave  : control unit side (consumes IR/mem_ready, drives strobes/status)
//   master : datapath/memory side (drives IR/mem_ready, consumes strobes)
// Strobes: bus drives (PCout, MDRout, Zlowout, Cout), register loads
// (PCin, MARin, MDRin, IRin, Yin, Zlowin), IncPc/read/write, register
// select (GRA, GRB, GRC, Rin, Rout, BAout), mdr_read source select,
// ALU op (control), halted/illegal status and the debug state code.
interface control_unit_if;
    logic [31:0] IR;
    logic        mem_ready;
    logic        PCout, MDRout, Zlowout, Cout;
    logic        PCin, MARin, MDRin, IRin, Yin, Zlowin;
    logic        IncPc, read, write;
    logic        GRA, GRB, GRC, Rin, Rout, BAout;
    logic [1:0]  mdr_read;
    logic [3:0]  control;
    logic        halted, illegal;
    logic [4:0]  state;

    modport slave (
        input  IR, mem_ready,
        output PCout, MDRout, Zlowout, Cout,
        output PCin, MARin, MDRin, IRin, Yin, Zlowin,
        output IncPc, read, write,
        output GRA, GRB, GRC, Rin, Rout, BAout,
        output mdr_read, control, halted, illegal, state
    );

    modport master (
        output IR, mem_ready,
        input  PCout, MDRout, Zlowout, Cout,
        input  PCin, MARin, MDRin, IRin, Yin, Zlowin,
        input  IncPc, read, write,
        input  GRA, GRB, GRC, Rin, Rout, BAout,
        input  mdr_read, control, halted, illegal, state
    );
endinterface

// File: rtl/control_unit.sv
// Hardwired multi-cycle control unit FSM.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous active-high reset
//   bus   - control_unit_if.slave: IR/mem_ready in, all strobes/status out
// Fetch is T0..T2; execute runs T3..T7 decoding IR[31:27] directly (the
// opcode is not latched). HALT is absorbing until reset.
module control_unit (
    input  logic          clk,
    input  logic          reset,
    control_unit_if.slave bus
);
    typedef enum logic [4:0] {
        S_RST = 5'd0, T0 = 5'd1, T1 = 5'd2, T2 = 5'd3, T3 = 5'd4,
        T4 = 5'd5, T5 = 5'd6, T6 = 5'd7, T7 = 5'd8, HALT = 5'd9
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_NOP  = 5'b11000;
    localparam logic [4:0] OP_HALT = 5'b11001;

    state_t     state_q, state_d;
    logic       illegal_q, set_illegal;
    logic [4:0] op;
    logic       is_ld, is_ldi, is_st, is_mem, is_alu;
    logic [3:0] alu_ctl;

    assign op     = bus.IR[31:27];
    assign is_ld  = (op == OP_LD);
    assign is_ldi = (op == OP_LDI);
    assign is_st  = (op == OP_ST);
    assign is_mem = is_ld | is_ldi | is_st;
    assign is_alu = (op == OP_ADD) | (op == OP_SUB) | (op == OP_AND) | (op == OP_OR);

    always_comb begin
        case (op)
            OP_ADD:  alu_ctl = 4'd2;
            OP_SUB:  alu_ctl = 4'd3;
            OP_AND:  alu_ctl = 4'd4;
            OP_OR:   alu_ctl = 4'd5;
            default: alu_ctl = 4'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_RST;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (set_illegal) illegal_q <= 1'b1;
        end
    end

    assign bus.state   = state_q;
    assign bus.illegal = illegal_q;

    always_comb begin
        state_d      = state_q;
        set_illegal  = 1'b0;
        bus.PCout    = 1'b0; bus.MDRout = 1'b0; bus.Zlowout = 1'b0; bus.Cout = 1'b0;
        bus.PCin     = 1'b0; bus.MARin  = 1'b0; bus.MDRin   = 1'b0; bus.IRin = 1'b0;
        bus.Yin      = 1'b0; bus.Zlowin = 1'b0;
        bus.IncPc    = 1'b0; bus.read   = 1'b0; bus.write   = 1'b0;
        bus.GRA      = 1'b0; bus.GRB    = 1'b0; bus.GRC     = 1'b0;
        bus.Rin      = 1'b0; bus.Rout   = 1'b0; bus.BAout   = 1'b0;
        bus.mdr_read = 2'b00;
        bus.control  = 4'd0;
        bus.halted   = 1'b0;

        case (state_q)
            S_RST: state_d = T0;
            T0: begin
                bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPc = 1'b1; bus.Zlowin = 1'b1;
                state_d = T1;
            end
            T1: begin
                bus.Zlowout = 1'b1; bus.read = 1'b1; bus.MDRin = 1'b1; bus.mdr_read = 2'b01;
                // PC loads only on the completing cycle so a stalled fetch
                // cannot write the incremented PC more than once.
                bus.PCin = bus.mem_ready;
                if (bus.mem_ready) state_d = T2;
            end
            T2: begin
                bus.MDRout = 1'b1; bus.IRin = 1'b1;
                if (op == OP_NOP)            state_d = T0;
                else if (op == OP_HALT)      state_d = HALT;
                else if (is_mem || is_alu)   state_d = T3;
                else begin
                    state_d     = HALT;
                    set_illegal = 1'b1;
                end
            end
            // IR is expected stable through execute; an opcode that turns
            // unexecutable mid-instruction is treated as illegal.
            T3: begin
                state_d = T4;
                if (is_mem) begin
                    bus.GRB = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
                end else if (is_alu) begin
                    bus.GRB = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
                end else begin
                    state_d = HALT; set_illegal = 1'b1;
                end
            end
            T4: begin
                state_d = T5;
                if (is_mem) begin
                    bus.Cout = 1'b1; bus.control = 4'd2; bus.Zlowin = 1'b1;
                end else if (is_alu) begin
                    bus.GRC = 1'b1; bus.Rout = 1'b1; bus.Zlowin = 1'b1; bus.control = alu_ctl;
                end else begin
                    state_d = HALT; set_illegal = 1'b1;
                end
            end
            T5: begin
                if (is_ld || is_st) begin
                    bus.Zlowout = 1'b1; bus.MARin = 1'b1; state_d = T6;
                end else if (is_ldi || is_alu) begin
                    bus.Zlowout = 1'b1; bus.GRA = 1'b1; bus.Rin = 1'b1; state_d = T0;
                end else begin
                    state_d = HALT; set_illegal = 1'b1;
                end
            end
            T6: begin
                if (is_ld) begin
                    bus.read = 1'b1; bus.MDRin = 1'b1; bus.mdr_read = 2'b01;
                    if (bus.mem_ready) state_d = T7;
                end else if (is_st) begin
                    bus.GRA = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1; bus.mdr_read = 2'b00;
                    state_d = T7;
                end else begin
                    state_d = HALT; set_illegal = 1'b1;
                end
            end
            T7: begin
                if (is_ld) begin
                    bus.MDRout = 1'b1; bus.GRA = 1'b1; bus.Rin = 1'b1; state_d = T0;
                end else if (is_st) begin
                    bus.write = 1'b1;
                    if (bus.mem_ready) state_d = T0;
                end else begin
                    state_d = HALT; set_illegal = 1'b1;
                end
            end
            HALT: bus.halted = 1'b1;
            default: state_d = S_RST;
        endcase
    end
endmodule
